// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer arbiter and its round-robin picker.
// Optional watchdog in the top is enabled by defining SPI_ARB_TIMEOUT_EN.
package spi_pkg;

    localparam int BYTES_W  = 3;
    localparam int DATA_W   = 32;
    localparam int SS_IDX_W = 3;

    localparam logic [BYTES_W-1:0] MAX_BYTES = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_FLUSH
    } arb_state_t;

    // A transaction moves between one and MAX_BYTES bytes; anything else is rejected.
    function automatic logic bytes_ok(input logic [BYTES_W-1:0] b);
        return (b != '0) && (b <= MAX_BYTES);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap-around.
// Emits a one-hot grant, the granted index and a valid flag.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               valid
);

    localparam logic [PW:0] NREQ = (PW+1)'(NUM_REQ);

    logic [PW:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!valid && req[cand[PW-1:0]]) begin
                valid               = 1'b1;
                gnt[cand[PW-1:0]]   = 1'b1;
                idx                 = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI byte engine between NUM_REQ requesters with round-robin grants and SS timing.
// Define SPI_ARB_TIMEOUT_EN to add a 16-bit XFER watchdog that aborts a stuck transfer.
module spi_xfer_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_SS   = 8,
    parameter int SS_SETUP = 4,
    parameter int SS_HOLD  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [NUM_REQ*3-1:0]   req_ss_i,
    input  logic [NUM_REQ*32-1:0]  req_wdata_i,
    input  logic [NUM_REQ*3-1:0]   req_bytes_i,
    output logic [NUM_REQ-1:0]     gnt_o,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [NUM_REQ-1:0]     err_o,
    output logic [31:0]            rdata_o,
    output logic                   busy_o,
    output logic [NUM_SS-1:0]      ss_o,
    output logic                   eng_enable_o,
    output logic [31:0]            eng_wdata_o,
    output logic [2:0]             eng_bytes_o,
    output logic                   eng_reset_fill_o,
    input  logic [31:0]            eng_rdata_i,
    input  logic [2:0]             eng_bytes_valid_i
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(SS_HOLD - 1);

    arb_state_t            state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         gnt_idx;
    logic [NUM_REQ-1:0]    arb_gnt;
    logic [PW-1:0]         arb_idx;
    logic                  arb_valid;
    logic [SS_IDX_W-1:0]   sel_ss;
    logic [BYTES_W-1:0]    sel_bytes;
    logic [DATA_W-1:0]     sel_wdata;
    logic [BYTES_W-1:0]    lat_bytes;
    logic [DATA_W-1:0]     lat_wdata;
    logic [15:0]           phase_cnt;
    logic [NUM_SS-1:0]     ss_dec;
`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0]           wd_cnt;
`endif

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
        return (i == PW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_i),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_ss    = '0;
        sel_bytes = '0;
        sel_wdata = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (arb_gnt[r]) begin
                sel_ss    = req_ss_i[3*r +: 3];
                sel_bytes = req_bytes_i[3*r +: 3];
                sel_wdata = req_wdata_i[32*r +: 32];
            end
        end
    end

    // An out-of-range slave index matches no line, so the transfer runs with all selects high.
    always_comb begin
        ss_dec = '1;
        for (int s = 0; s < NUM_SS; s++) begin
            if (sel_ss == SS_IDX_W'(s)) begin
                ss_dec[s] = 1'b0;
            end
        end
    end

    assign busy_o = (state != ST_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= ST_IDLE;
            rr_ptr           <= '0;
            gnt_idx          <= '0;
            gnt_o            <= '0;
            done_o           <= '0;
            err_o            <= '0;
            rdata_o          <= '0;
            ss_o             <= '1;
            eng_enable_o     <= 1'b0;
            eng_wdata_o      <= '0;
            eng_bytes_o      <= '0;
            eng_reset_fill_o <= 1'b0;
            lat_bytes        <= '0;
            lat_wdata        <= '0;
            phase_cnt        <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            wd_cnt           <= '0;
`endif
        end else begin
            done_o           <= '0;
            err_o            <= '0;
            eng_reset_fill_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        lat_bytes <= sel_bytes;
                        lat_wdata <= sel_wdata;
                        gnt_idx   <= arb_idx;
                        if (!bytes_ok(sel_bytes)) begin
                            err_o  <= arb_gnt;
                            rr_ptr <= next_ptr(arb_idx);
                        end else begin
                            gnt_o     <= arb_gnt;
                            ss_o      <= ss_dec;
                            phase_cnt <= '0;
                            state     <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (phase_cnt == SETUP_LAST) begin
                        eng_enable_o <= 1'b1;
                        eng_wdata_o  <= lat_wdata;
                        eng_bytes_o  <= lat_bytes;
`ifdef SPI_ARB_TIMEOUT_EN
                        wd_cnt       <= 16'd1;
`endif
                        state        <= ST_XFER;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                ST_XFER: begin
                    if (eng_bytes_valid_i == lat_bytes) begin
                        rdata_o      <= eng_rdata_i;
                        eng_enable_o <= 1'b0;
                        eng_wdata_o  <= '0;
                        eng_bytes_o  <= '0;
                        phase_cnt    <= '0;
                        state        <= ST_HOLD;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    // Watchdog abort: no done, rdata keeps the previous word.
                    else if (wd_cnt == 16'hFFFF) begin
                        eng_enable_o     <= 1'b0;
                        eng_wdata_o      <= '0;
                        eng_bytes_o      <= '0;
                        ss_o             <= '1;
                        eng_reset_fill_o <= 1'b1;
                        err_o            <= gnt_o;
                        gnt_o            <= '0;
                        rr_ptr           <= next_ptr(gnt_idx);
                        state            <= ST_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                ST_HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        ss_o             <= '1;
                        eng_reset_fill_o <= 1'b1;
                        done_o           <= gnt_o;
                        rr_ptr           <= next_ptr(gnt_idx);
                        state            <= ST_FLUSH;
                    end else begin
                        phase_cnt <= phase_cnt + 16'd1;
                    end
                end
                ST_FLUSH: begin
                    gnt_o <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a loopback engine model; SPI_ARB_TIMEOUT_EN adds the watchdog case.
module tb_spi_xfer_arbiter;

    localparam int NUM_REQ = 2;
    localparam int NUM_SS  = 8;
    localparam int ENG_LAT = 8;
    localparam int LIMIT   = 200;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ*3-1:0]  req_ss = '0;
    logic [NUM_REQ*32-1:0] req_wdata = '0;
    logic [NUM_REQ*3-1:0]  req_bytes = '0;
    logic [NUM_REQ-1:0]    gnt_o, done_o, err_o;
    logic [31:0]           rdata_o;
    logic                  busy_o;
    logic [NUM_SS-1:0]     ss_o;
    logic                  eng_enable_o;
    logic [31:0]           eng_wdata_o;
    logic [2:0]            eng_bytes_o;
    logic                  eng_reset_fill_o;
    logic [31:0]           eng_rdata = '0;
    logic [2:0]            eng_bytes_valid = '0;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    bit hang = 1'b0;
    int eng_cnt = 0;

    spi_xfer_arbiter #(
        .NUM_REQ(NUM_REQ), .NUM_SS(NUM_SS), .SS_SETUP(4), .SS_HOLD(4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .req_i             (req),
        .req_ss_i          (req_ss),
        .req_wdata_i       (req_wdata),
        .req_bytes_i       (req_bytes),
        .gnt_o             (gnt_o),
        .done_o            (done_o),
        .err_o             (err_o),
        .rdata_o           (rdata_o),
        .busy_o            (busy_o),
        .ss_o              (ss_o),
        .eng_enable_o      (eng_enable_o),
        .eng_wdata_o       (eng_wdata_o),
        .eng_bytes_o       (eng_bytes_o),
        .eng_reset_fill_o  (eng_reset_fill_o),
        .eng_rdata_i       (eng_rdata),
        .eng_bytes_valid_i (eng_bytes_valid)
    );

    always #5 clk = ~clk;

    // Loopback engine: reports all bytes ENG_LAT cycles after enable, echoing the TX word.
    always @(negedge clk) begin
        if (!eng_enable_o) begin
            eng_cnt         = 0;
            eng_bytes_valid = '0;
        end else begin
            eng_cnt++;
            if (hang) begin
                eng_bytes_valid = 3'd1;
            end else if (eng_cnt >= ENG_LAT) begin
                eng_bytes_valid = eng_bytes_o;
                eng_rdata       = eng_wdata_o;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [2:0] ss, input logic [31:0] wd, input logic [2:0] nb);
        req_ss[3*r +: 3]     = ss;
        req_wdata[32*r +: 32] = wd;
        req_bytes[3*r +: 3]  = nb;
    endtask

    task automatic run_xfer(input int r, input logic [2:0] ss, input logic [31:0] wd,
                            input logic [2:0] nb, input bit drop_in_hold);
        int n;
        logic [NUM_REQ-1:0] onehot;
        logic [7:0] exp_ss;
        onehot    = '0;
        onehot[r] = 1'b1;
        exp_ss    = ~(8'h01 << ss);
        set_req(r, ss, wd, nb);
        req[r] = 1'b1;
        n = 0;
        @(negedge clk);
        while (ss_o == '1 && n < LIMIT) begin n++; @(negedge clk); end
        check("grant_wait", 32'(n), 32'd0);
        check("ss_assert", 32'(ss_o), 32'(exp_ss));
        check("gnt", 32'(gnt_o), 32'(onehot));
        n = 0;
        while (!eng_enable_o && n < LIMIT) begin n++; @(negedge clk); end
        check("setup_cycles", 32'(n), 32'd4);
        check("eng_bytes", 32'(eng_bytes_o), 32'(nb));
        check("eng_wdata", eng_wdata_o, wd);
        check("ss_in_xfer", 32'(ss_o), 32'(exp_ss));
        n = 0;
        while (eng_enable_o && n < LIMIT) begin n++; @(negedge clk); end
        check("xfer_cycles", 32'(n), 32'(ENG_LAT));
        if (drop_in_hold) req[r] = 1'b0;
        n = 0;
        while (ss_o != '1 && n < LIMIT) begin n++; @(negedge clk); end
        check("hold_cycles", 32'(n), 32'd4);
        check("done", 32'(done_o), 32'(onehot));
        check("rdata", rdata_o, wd);
        check("flush_fill", 32'(eng_reset_fill_o), 32'd1);
        check("gnt_in_flush", 32'(gnt_o), 32'(onehot));
        req[r] = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(done_o), 32'd0);
        check("gnt_clear", 32'(gnt_o), 32'd0);
        check("busy_idle", 32'(busy_o), 32'd0);
    endtask

    task automatic bad_count(input int r, input logic [2:0] nb);
        int errs;
        bit early, ss_ok, en_ok;
        errs = 0; early = 1'b0; ss_ok = 1'b1; en_ok = 1'b1;
        set_req(r, 3'd1, 32'hCAFE_0001, nb);
        req[r] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (err_o[r]) begin
                errs++;
                if (i < 2) early = 1'b1;
                req[r] = 1'b0;
            end
            if (ss_o != '1) ss_ok = 1'b0;
            if (eng_enable_o) en_ok = 1'b0;
        end
        req[r] = 1'b0;
        check("bad_err_count", 32'(errs), 32'd1);
        check("bad_err_early", 32'(early), 32'd1);
        check("bad_ss_idle", 32'(ss_ok), 32'd1);
        check("bad_no_enable", 32'(en_ok), 32'd1);
        check("bad_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic contention();
        int n, r, prev;
        int cnt[2];
        cnt[0] = 0; cnt[1] = 0; prev = -1;
        // Pointer sits at 1 after the preceding requester-0 transactions.
        for (int k = 0; k < 8; k++) exp_q.push_back((k % 2 == 0) ? 32'd2 : 32'd1);
        set_req(0, 3'd0, 32'h1111_2222, 3'd4);
        set_req(1, 3'd5, 32'h3333_4444, 3'd3);
        req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n = 0;
            while (done_o == '0 && n < LIMIT) begin n++; @(negedge clk); end
            check("rr_order", 32'(done_o), exp_q.pop_front());
            r = done_o[1] ? 1 : 0;
            check("rr_no_repeat", 32'(r != prev), 32'd1);
            check("rr_rdata", rdata_o, (r == 1) ? 32'h3333_4444 : 32'h1111_2222);
            prev = r;
            cnt[r]++;
            if (cnt[r] == 4) req[r] = 1'b0;
        end
        check("rr_cnt0", 32'(cnt[0]), 32'd4);
        check("rr_cnt1", 32'(cnt[1]), 32'd4);
    endtask

    task automatic reset_mid_xfer();
        int n;
        set_req(0, 3'd3, 32'h0BAD_F00D, 3'd4);
        req[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!eng_enable_o && n < LIMIT) begin n++; @(negedge clk); end
        check("rst_pre_enable", 32'(eng_enable_o), 32'd1);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ss", 32'(ss_o), 32'hFF);
        check("rst_async_en", 32'(eng_enable_o), 32'd0);
        check("rst_async_gnt", 32'(gnt_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        req[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o != '0) n++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_o != '0) n++;
        end
        check("rst_no_done", 32'(n), 32'd0);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic watchdog();
        int n;
        logic [31:0] prev_rdata;
        prev_rdata = rdata_o;
        hang = 1'b1;
        set_req(0, 3'd0, 32'h7777_8888, 3'd2);
        req[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!eng_enable_o && n < LIMIT) begin n++; @(negedge clk); end
        n = 0;
        while (eng_enable_o && n < 70000) begin n++; @(negedge clk); end
        check("wd_cycles", 32'(n), 32'd65535);
        check("wd_err", 32'(err_o), 32'd1);
        check("wd_fill", 32'(eng_reset_fill_o), 32'd1);
        check("wd_no_done", 32'(done_o), 32'd0);
        check("wd_rdata", rdata_o, prev_rdata);
        check("wd_ss", 32'(ss_o), 32'hFF);
        req[0] = 1'b0;
        hang = 1'b0;
        @(negedge clk);
        check("wd_err_pulse", 32'(err_o), 32'd0);
    endtask
`endif

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_ss", 32'(ss_o), 32'hFF);
        check("reset_gnt", 32'(gnt_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_err", 32'(err_o), 32'd0);
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_en", 32'(eng_enable_o), 32'd0);
        check("reset_wdata", eng_wdata_o, 32'd0);
        check("reset_bytes", 32'(eng_bytes_o), 32'd0);
        check("reset_fill", 32'(eng_reset_fill_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_xfer(0, 3'd2, 32'hA5A5_1234, 3'd4, 1'b0);
        run_xfer(0, 3'd7, 32'h0000_00C3, 3'd1, 1'b1);
        contention();
        bad_count(1, 3'd0);
        bad_count(1, 3'd5);
        reset_mid_xfer();
        run_xfer(0, 3'd6, 32'hDEAD_BEEF, 3'd4, 1'b0);
`ifdef SPI_ARB_TIMEOUT_EN
        watchdog();
`endif
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
